// File: rtl/alu_arbiter_if.sv
// Requester, ALU and response signals shared between alu_arbiter and its neighbours.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface alu_arbiter_if #(
  parameter int unsigned W  = 1,
  parameter int unsigned CW = 3
);
  logic          req0_valid;
  logic          req0_ready;
  logic [W-1:0]  req0_a;
  logic [W-1:0]  req0_b;
  logic [CW-1:0] req0_cod;

  logic          req1_valid;
  logic          req1_ready;
  logic [W-1:0]  req1_a;
  logic [W-1:0]  req1_b;
  logic [CW-1:0] req1_cod;

  logic [W-1:0]  alu_op1;
  logic [W-1:0]  alu_op2;
  logic [CW-1:0] alu_codigo;
  logic [W-1:0]  alu_res;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_res;
  logic          rsp_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cod,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cod,
    output req1_ready,
    output alu_op1, alu_op2, alu_codigo,
    input  alu_res,
    output rsp_valid, rsp_res, rsp_id,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cod,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cod,
    input  req1_ready,
    input  alu_op1, alu_op2, alu_codigo,
    output alu_res,
    input  rsp_valid, rsp_res, rsp_id,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Operands are issued from registers, the result is captured and returned tagged with the requester id.
module alu_arbiter #(
  parameter int unsigned W  = 1,
  parameter int unsigned CW = 3
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          last_gnt;
  logic          id_reg;

  logic          any_valid_c;
  logic          gnt_c;
  logic [W-1:0]  sel_a_c;
  logic [W-1:0]  sel_b_c;
  logic [CW-1:0] sel_cod_c;

  logic          load_c;
  logic          capture_c;
  logic          done_c;
  logic          ready0_c;
  logic          ready1_c;

  logic [W-1:0]  op1_q;
  logic [W-1:0]  op2_q;
  logic [CW-1:0] cod_q;
  logic [W-1:0]  res_q;
  logic          rsp_valid_q;
  logic          rsp_id_q;

  // Round-robin pick: a lone requester wins, on contention the one not served last wins
  always_comb begin
    any_valid_c = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_c = ~last_gnt;
    end else begin
      gnt_c = bus.req1_valid;
    end
    sel_a_c   = gnt_c ? bus.req1_a   : bus.req0_a;
    sel_b_c   = gnt_c ? bus.req1_b   : bus.req0_b;
    sel_cod_c = gnt_c ? bus.req1_cod : bus.req0_cod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_valid_c) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Readies are gated by rst so nothing is accepted in a reset cycle
  always_comb begin
    load_c    = 1'b0;
    capture_c = 1'b0;
    done_c    = 1'b0;
    ready0_c  = 1'b0;
    ready1_c  = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid_c && !rst) begin
          load_c   = 1'b1;
          ready0_c = ~gnt_c;
          ready1_c = gnt_c;
        end
      end
      EXEC: begin
        capture_c = 1'b1;
      end
      RESP: begin
        done_c = bus.rsp_ready;
      end
      default: begin
        load_c = 1'b0;
      end
    endcase
  end

  // ALU operand registers, result capture and response bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q       <= '0;
      op2_q       <= '0;
      cod_q       <= '0;
      id_reg      <= 1'b0;
      last_gnt    <= 1'b1;
      res_q       <= '0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (load_c) begin
        op1_q  <= sel_a_c;
        op2_q  <= sel_b_c;
        cod_q  <= sel_cod_c;
        id_reg <= gnt_c;
      end
      if (capture_c) begin
        res_q       <= bus.alu_res;
        rsp_id_q    <= id_reg;
        last_gnt    <= id_reg;
        rsp_valid_q <= 1'b1;
      end
      if (done_c) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = ready0_c;
  assign bus.req1_ready = ready1_c;
  assign bus.alu_op1    = op1_q;
  assign bus.alu_op2    = op2_q;
  assign bus.alu_codigo = cod_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_res    = res_q;
  assign bus.rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle plus directed literal checks.
// The bench supplies the ALU; its reference function is used both as the ALU and for expected results.
module tb_alu_arbiter;
  localparam int unsigned W  = 1;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_arbiter_if #(.W(W), .CW(CW)) bus ();

  alu_arbiter #(.W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [CW-1:0] c);
    case (c)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return W'(a + b);
      3'd4:    return W'(a - b);
      3'd5:    return ~a;
      3'd6:    return b;
      default: return ~(a ^ b);
    endcase
  endfunction

  assign bus.alu_res = ref_alu(bus.alu_op1, bus.alu_op2, bus.alu_codigo);

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // Model: one outstanding operation at most, aged in cycles since its accept
  bit            m_pend   = 1'b0;
  int            m_age    = 0;
  logic          m_last   = 1'b1;
  logic          m_id     = 1'b0;
  logic [W-1:0]  m_op1    = '0;
  logic [W-1:0]  m_op2    = '0;
  logic [CW-1:0] m_cod    = '0;
  logic [W-1:0]  m_res    = '0;
  logic          m_rsp_id = 1'b0;
  int            glog_id[$];
  int            glog_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : model
    logic v0, v1, gv, g, exp_rv;
    v0     = bus.req0_valid;
    v1     = bus.req1_valid;
    gv     = !rst && !m_pend && (v0 || v1);
    g      = (v0 && v1) ? ~m_last : v1;
    exp_rv = m_pend && (m_age >= 2);
    if (chk_en) begin
      check("req0_ready", 32'(bus.req0_ready), 32'(gv && !g));
      check("req1_ready", 32'(bus.req1_ready), 32'(gv && g));
      check("alu_op1", 32'(bus.alu_op1), 32'(m_op1));
      check("alu_op2", 32'(bus.alu_op2), 32'(m_op2));
      check("alu_codigo", 32'(bus.alu_codigo), 32'(m_cod));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      check("rsp_res", 32'(bus.rsp_res), 32'(m_res));
      check("rsp_id", 32'(bus.rsp_id), 32'(m_rsp_id));
    end
    if (gv) begin
      glog_id.push_back(int'(g));
      glog_cyc.push_back(cyc);
    end
    cyc++;
    if (rst) begin
      m_pend = 1'b0; m_age = 0; m_last = 1'b1; m_id = 1'b0;
      m_op1 = '0; m_op2 = '0; m_cod = '0; m_res = '0; m_rsp_id = 1'b0;
    end else if (m_pend) begin
      if (m_age == 1) begin
        m_res    = ref_alu(m_op1, m_op2, m_cod);
        m_rsp_id = m_id;
        m_last   = m_id;
        m_age    = 2;
      end else if (bus.rsp_ready) begin
        m_pend = 1'b0;
      end
    end else if (gv) begin
      m_pend = 1'b1;
      m_age  = 1;
      m_id   = g;
      m_op1  = g ? bus.req1_a   : bus.req0_a;
      m_op2  = g ? bus.req1_b   : bus.req0_b;
      m_cod  = g ? bus.req1_cod : bus.req0_cod;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [CW-1:0] c);
    if (id) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cod = c;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cod = c;
    end
  endtask

  // Issue one operation and follow it to its response handshake (rsp_ready assumed high)
  task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [CW-1:0] c);
    bit ok;
    set_req(id, 1'b1, a, b, c);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("op accepted", 32'(ok), 32'd1);
    tick();
    set_req(id, 1'b0, a, b, c);
    @(negedge clk);
    check("op issued codigo", 32'(bus.alu_codigo), 32'(c));
    check("op issued op1", 32'(bus.alu_op1), 32'(a));
    check("op issued op2", 32'(bus.alu_op2), 32'(b));
    tick();
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("op response seen", 32'(ok), 32'd1);
    check("op response res", 32'(bus.rsp_res), 32'(ref_alu(a, b, c)));
    check("op response id", 32'(bus.rsp_id), 32'(id));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // First operation after reset: req0 OR(1,0)
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 3'b001);
    @(negedge clk);
    check("t1 req0_ready c0", 32'(bus.req0_ready), 32'd1);
    tick();
    set_req(1'b0, 1'b0, 1'b1, 1'b0, 3'b001);
    @(negedge clk);
    check("t1 alu_op1 c1", 32'(bus.alu_op1), 32'd1);
    check("t1 alu_op2 c1", 32'(bus.alu_op2), 32'd0);
    check("t1 alu_codigo c1", 32'(bus.alu_codigo), 32'd1);
    check("t1 rsp_valid c1", 32'(bus.rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t1 rsp_valid c2", 32'(bus.rsp_valid), 32'd1);
    check("t1 rsp_id c2", 32'(bus.rsp_id), 32'd0);
    check("t1 rsp_res c2", 32'(bus.rsp_res), 32'd1);
    tick();

    // Continuous contention from reset: grants 0,1,0,1 every 3 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    glog_id.delete();
    glog_cyc.delete();
    set_req(1'b0, 1'b1, 1'b1, 1'b1, 3'd2);
    set_req(1'b1, 1'b1, 1'b0, 1'b1, 3'd3);
    repeat (12) tick();
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    check("t2 grant count", 32'(glog_id.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < glog_id.size()) check("t2 grant id", 32'(glog_id[i]), 32'(i % 2));
    end
    for (int i = 1; i < 4; i++) begin
      if (i < glog_cyc.size()) check("t2 grant spacing", 32'(glog_cyc[i] - glog_cyc[i-1]), 32'd3);
    end
    repeat (4) tick();

    // Backpressure: response held 5 cycles, req1 waits and is taken right after handshake
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
    @(negedge clk);
    check("t3 req0_ready", 32'(bus.req0_ready), 32'd1);
    tick();
    set_req(1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    set_req(1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
    @(negedge clk);
    check("t3 req1_ready exec", 32'(bus.req1_ready), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3 held rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("t3 held rsp_res", 32'(bus.rsp_res), 32'd1);
      check("t3 held rsp_id", 32'(bus.rsp_id), 32'd0);
      check("t3 req1 blocked", 32'(bus.req1_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("t3 handshake req1_ready", 32'(bus.req1_ready), 32'd0);
    tick();
    @(negedge clk);
    check("t3 req1 accepted after", 32'(bus.req1_ready), 32'd1);
    tick();
    set_req(1'b1, 1'b0, '0, '0, '0);
    repeat (3) tick();

    // Lone req1 with XNOR(1,1)
    do_op(1'b1, 1'b1, 1'b1, 3'b111);
    check("t4 rsp_res", 32'(bus.rsp_res), 32'd1);
    check("t4 rsp_id", 32'(bus.rsp_id), 32'd1);

    // Reset during EXEC discards the operation
    set_req(1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
    @(negedge clk);
    check("t5 req1_ready", 32'(bus.req1_ready), 32'd1);
    tick();
    set_req(1'b1, 1'b0, '0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5 exec abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5 exec abort op1", 32'(bus.alu_op1), 32'd0);
    check("t5 exec abort codigo", 32'(bus.alu_codigo), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("t5 no late response", 32'(bus.rsp_valid), 32'd0);
    end
    tick();

    // Reset during RESP, then immediate contention grants requester 0
    bus.rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 1'b1, 1'b1, 3'd2);
    @(negedge clk);
    check("t5 req0_ready", 32'(bus.req0_ready), 32'd1);
    tick();
    set_req(1'b0, 1'b0, '0, '0, '0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t5 resp before reset", 32'(bus.rsp_valid), 32'd1);
    tick();
    rst = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 1'b1, 3'd4);
    set_req(1'b1, 1'b1, 1'b1, 1'b1, 3'd5);
    @(negedge clk);
    check("t5 resp abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5 resp abort op2", 32'(bus.alu_op2), 32'd0);
    check("t5 resp abort codigo", 32'(bus.alu_codigo), 32'd0);
    check("t5 contention req0_ready", 32'(bus.req0_ready), 32'd1);
    check("t5 contention req1_ready", 32'(bus.req1_ready), 32'd0);
    tick();
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    bus.rsp_ready = 1'b1;
    repeat (4) tick();

    // Sweep every code over all operand pairs, alternating requesters
    for (int c = 0; c < 8; c++) begin
      for (int ab = 0; ab < 4; ab++) begin
        logic [1:0] abv;
        abv = 2'(ab);
        do_op(1'(ab), abv[1], abv[0], 3'(c));
      end
    end
    check("sweep ADD(1,1) pin", 32'(ref_alu(1'b1, 1'b1, 3'd3)), 32'd0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU between two requesters. Each requester presents operands and a 3-bit operation code with a valid/ready handshake. The block arbitrates round-robin, drives the ALU from registered operands, captures the ALU result and returns it on a response channel tagged with the requester id. It sits between the requesting control logic and the ALU instance, and is the only driver of the ALU's OP1/OP2/codigo inputs.

## Interface
- W, 1: operand and result width; must equal the ALU operand width.
- CW, 3: operation code width, passed to ALU codigo unchanged.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  W  requester 0 operands.
- req0_cod  in  CW  requester 0 operation code.
- req1_valid, req1_ready, req1_a, req1_b, req1_cod: same as requester 0, for requester 1.
- alu_op1, alu_op2  out  W  to ALU OP1/OP2, registered.
- alu_codigo  out  CW  to ALU codigo, registered.
- alu_res  in  W  combinational ALU result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_res  out  W  captured ALU result.
- rsp_id  out  1  requester id of the response (0 or 1).

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE:
  - If no valid is present, stay in IDLE.
  - Otherwise grant per round-robin. If only one is valid, grant it. If both are valid, grant the one different from last_gnt.
  - Assert req<g>_ready combinationally in that cycle. Load alu_op1/alu_op2/alu_codigo from the granted requester's a/b/cod, set id_reg=g, go to EXEC.
- EXEC: ALU inputs are stable from the registers. On the clock edge, capture alu_res into rsp_res, set last_gnt=id_reg, go to RESP.
- RESP:
  - rsp_valid=1; rsp_res and rsp_id are held stable.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - No new request is accepted until back in IDLE.
- req*_ready is 1 only in IDLE, only for the granted requester, and only when that requester is valid. Both readies are never high together.
- Requesters hold valid and payload until ready. The block samples the payload only in the ready cycle.
- alu_op1/alu_op2/alu_codigo keep their last issued values outside the load cycle. There is no glitching on the ALU inputs between operations.
- Codes are not decoded or checked; every CW-bit value is forwarded.
- Reset values: state=IDLE, last_gnt=1 (requester 0 wins the first contention), alu_op1=alu_op2=0, alu_codigo=0, rsp_valid=0, rsp_res=0, rsp_id=0, both readies 0.
- rst in EXEC or RESP aborts the operation: the pending response is discarded and all outputs return to reset values the next cycle.

## Timing
- Accept in cycle N (ready high). ALU inputs are updated after edge N. Result is captured at edge N+1. rsp_valid is high from cycle N+2.
- If rsp_ready is high in N+2, the block is back in IDLE at N+3. The next accept is possible in N+3, giving a minimum of 3 cycles per operation.
- Backpressure: rsp_valid stays high for as many cycles as rsp_ready stays low, with outputs held constant.
- A request arriving during EXEC or RESP waits and is accepted in the first IDLE cycle.
- last_gnt updates only on completed operations, never on aborted ones.
- When both requesters stay continuously valid, grants alternate 0,1,0,1 starting with 0 after reset.

## Test plan
- After reset, assert req0 with a=1, b=0, cod=3'b001. Required: req0_ready=1 in cycle 0; alu_op1=1, alu_op2=0, alu_codigo=001 from cycle 1; rsp_valid=1 in cycle 2 with rsp_id=0 and rsp_res equal to the ALU output for code 001.
- Hold req0 and req1 valid continuously with rsp_ready=1. Required: grant sequence 0,1,0,1; each rsp_id matches; accepts exactly every 3 cycles.
- Hold rsp_ready=0 for 5 cycles after rsp_valid rises. Required: rsp_valid, rsp_res and rsp_id are constant; req1_ready stays 0 despite req1_valid=1; req1 is accepted the cycle after the response handshake completes.
- Assert only req1 with a=1, b=1, cod=3'b111. Required: req1 is granted immediately and rsp_id=1; req0_ready stays 0 throughout.
- Assert rst during EXEC, then again during RESP. Required: next cycle rsp_valid=0, ALU outputs 0, state IDLE, and the discarded operation produces no response. A subsequent contention grants requester 0.
- Sweep cod 000..111 with a,b over all four combinations. Required: alu_codigo equals the issued cod, and rsp_res equals the ALU reference result for every case.
